sdram_avmm_arbiter: RTL

- Two-master Avalon-MM arbiter sharing the single 16-bit Avalon-MM slave port of the W9825G6KH SDRAM controller (100 MHz, CL3) between requesters on the same clock, e.g. the Nios/PIO subsystem and a DMA or pattern tester.
- Per-transfer round-robin grant.
- Tracks outstanding pipelined reads so each readdatavalid is routed to the master that issued the read.
- Sits between the masters and the SDRAM controller slave inside the controller top level.

---
 rtl/sdram_avmm_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sdram_avmm_arbiter.sv
// Two-master Avalon-MM arbiter for the SDRAM controller slave port; per-transfer round-robin
// (fixed priority to master 0 when SDRAM_ARB_FIXED_PRIO_EN is defined), read IDs tracked for response routing.
module sdram_avmm_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_o
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                 state;
    logic                   grant;
    logic [MAX_PENDING-1:0] id_mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   err;

    logic req0, req1, g_read, g_write, g_req, busy;
    logic fifo_full, fifo_empty, read_blocked, accept, push, pop, head_id;
    logic idle_winner, accept_grant;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    // A read asserted together with a write is flagged and executed as the write.
    assign g_read     = grant ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
    assign g_write    = grant ? m1_write : m0_write;
    assign g_req      = g_read | g_write;
    assign busy       = (state == GRANTED);
    assign fifo_full  = (count == CNT_W'(MAX_PENDING));
    assign fifo_empty = (count == '0);

    assign read_blocked = busy & g_read & fifo_full;
    assign s_read       = busy & g_read & ~fifo_full;
    assign s_write      = busy & g_write;
    assign accept       = (s_read | s_write) & ~s_waitrequest;
    assign push         = accept & s_read;
    assign pop          = s_readdatavalid & ~fifo_empty;
    assign head_id      = id_mem[rd_ptr];

    assign s_address    = grant ? m1_address    : m0_address;
    assign s_writedata  = grant ? m1_writedata  : m0_writedata;
    assign s_byteenable = grant ? m1_byteenable : m0_byteenable;

    assign m0_waitrequest   = ~(busy & ~grant) | s_waitrequest | read_blocked;
    assign m1_waitrequest   = ~(busy &  grant) | s_waitrequest | read_blocked;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop &  head_id;
    assign err_o            = err;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign idle_winner  = ~req0;
    assign accept_grant = ~req0;
`else
    logic rr_last;
    // Prefer the master that did not win last; fall back to the sole requester.
    assign idle_winner  = (rr_last ? req0 : req1) ? ~rr_last : rr_last;
    assign accept_grant = (grant ? req0 : req1) ? ~grant : grant;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            rr_last <= 1'b1;
        else if (busy && accept)
            rr_last <= grant;
    end
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state  <= IDLE;
            grant  <= 1'b0;
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant <= idle_winner;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (accept) begin
                        if (req0 | req1)
                            grant <= accept_grant;
                        else
                            state <= IDLE;
                    end else if (!g_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            if ((m0_read & m0_write) | (m1_read & m1_write) | (s_readdatavalid & fifo_empty))
                err <= 1'b1;
        end
    end

endmodule
